// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU codes,
// immediate selectors and the bit positions inside the control bundle.
package ctrl_pkg;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  // M-extension codes are {1'b1, 1'b0, funct3}
  localparam logic [1:0] ALU_MEXT_HI = 2'b10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam int SIG_REGWRITE  = 0;
  localparam int SIG_REGSRC    = 1;
  localparam int SIG_MEMREAD   = 2;
  localparam int SIG_MEMWRITE  = 3;
  localparam int SIG_PCRS1SEL  = 4;
  localparam int SIG_BRANCH    = 5;
  localparam int SIG_ALUSRC    = 6;
  localparam int SIG_ALUC_LSB  = 7;

  // immsel sits directly above alucontrol, whose width depends on EN_MEXT
  function automatic int sig_immsel_lsb(input int aluc_w);
    return SIG_ALUC_LSB + aluc_w;
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I(+M) control decode: instr -> control bundle, illegal
// flag and which source registers the instruction reads.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int EN_MEXT = 0,
  localparam int ALUC_W = 4 + EN_MEXT,
  localparam int SIG_W  = 10 + ALUC_W
) (
  input  logic [31:0]      instr,
  output logic [SIG_W-1:0] sigs,
  output logic             illegal,
  output logic             uses_rs1,
  output logic             uses_rs2
);
  localparam int IMM_LSB = sig_immsel_lsb(ALUC_W);

  logic [4:0] op;
  logic [2:0] f3;
  logic [6:0] ctl;
  logic [4:0] alu;
  logic [2:0] imm;
  logic       unused_bits;

  assign op = instr[6:2];
  assign f3 = instr[14:12];
  assign unused_bits = ^{instr[31], instr[29:26], instr[24:15], instr[11:7], instr[1:0]};

  always_comb begin
    ctl     = '0;
    alu     = '0;
    imm     = IMM_I;
    illegal = 1'b0;
    case (op)
      OP_R: begin
        ctl[SIG_REGWRITE] = 1'b1;
        if (instr[25]) begin
          if (EN_MEXT != 0) alu = {ALU_MEXT_HI, f3};
          else              illegal = 1'b1;
        end else begin
          alu = {1'b0, instr[30], f3};
        end
      end
      OP_IMM: begin
        ctl[SIG_REGWRITE] = 1'b1;
        ctl[SIG_ALUSRC]   = 1'b1;
        alu = {1'b0, (f3 == 3'b101) & instr[30], f3};
      end
      OP_LOAD: begin
        ctl[SIG_REGWRITE] = 1'b1;
        ctl[SIG_REGSRC]   = 1'b1;
        ctl[SIG_MEMREAD]  = 1'b1;
        ctl[SIG_ALUSRC]   = 1'b1;
        alu = {1'b0, ALU_ADD};
      end
      OP_STORE: begin
        ctl[SIG_MEMWRITE] = 1'b1;
        ctl[SIG_ALUSRC]   = 1'b1;
        alu = {1'b0, ALU_ADD};
        imm = IMM_S;
      end
      OP_BRANCH: begin
        ctl[SIG_BRANCH] = 1'b1;
        alu = {1'b0, ALU_SUB};
        imm = IMM_B;
      end
      OP_JAL: begin
        ctl[SIG_REGWRITE] = 1'b1;
        ctl[SIG_BRANCH]   = 1'b1;
        imm = IMM_J;
      end
      OP_JALR: begin
        ctl[SIG_REGWRITE] = 1'b1;
        ctl[SIG_BRANCH]   = 1'b1;
        ctl[SIG_PCRS1SEL] = 1'b1;
        ctl[SIG_ALUSRC]   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        ctl[SIG_REGWRITE] = 1'b1;
        ctl[SIG_ALUSRC]   = 1'b1;
        imm = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    sigs = '0;
    if (!illegal) begin
      sigs[SIG_ALUC_LSB-1:0]        = ctl;
      sigs[SIG_ALUC_LSB +: ALUC_W]  = alu[ALUC_W-1:0];
      sigs[IMM_LSB +: 3]            = imm;
    end
  end

  assign uses_rs1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign uses_rs2 = op inside {OP_R, OP_STORE, OP_BRANCH};
endmodule

// File: rtl/pipe_controller.sv
// ID/EX stage: decodes one instruction per cycle into a registered control
// bundle with valid/ready handshake, load-use bubbling and flush.
module pipe_controller
  import ctrl_pkg::*;
#(
  parameter int EN_MEXT   = 0,
  parameter int EN_HAZARD = 1,
  parameter int ILL_CNT_W = 16,
  localparam int ALUC_W = 4 + EN_MEXT,
  localparam int SIG_W  = 10 + ALUC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIG_W-1:0]     out_sigs,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_cnt
);
  logic [SIG_W-1:0] dec_sigs;
  logic             dec_illegal;
  logic             uses_rs1;
  logic             uses_rs2;
  logic             hazard;
  logic             accept;
  logic [4:0]       rs1;
  logic [4:0]       rs2;

  ctrl_decode #(.EN_MEXT(EN_MEXT)) u_dec (
    .instr    (instr),
    .sigs     (dec_sigs),
    .illegal  (dec_illegal),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  // A load still in the stage cannot forward; the consumer waits one bubble.
  assign hazard = (EN_HAZARD != 0) && out_valid && out_sigs[SIG_MEMREAD] && (out_rd != 5'd0) &&
                  ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd));

  assign in_ready = (!out_valid || out_ready) && !flush && !hazard && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_sigs    <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_illegal <= 1'b0;
      ill_cnt     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_sigs    <= dec_sigs;
      out_rd      <= instr[11:7];
      out_rs1     <= rs1;
      out_rs2     <= rs2;
      out_illegal <= dec_illegal;
      if (dec_illegal && ill_cnt != {ILL_CNT_W{1'b1}}) ill_cnt <= ill_cnt + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: directed scenarios plus a randomized run
// against a cycle-level reference of the stage built from the decode table.
module tb_pipe_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main instance: M-extension on, 2-bit counter
  logic        in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] instr = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [14:0] out_sigs;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [1:0]  ill_cnt;

  // second instance: base ISA only, default counter width
  logic        b_in_valid = 0, b_flush = 0, b_out_ready = 0;
  logic [31:0] b_instr = '0;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [13:0] b_out_sigs;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
  logic [15:0] b_ill_cnt;

  int errors = 0;
  int checks = 0;

  pipe_controller #(.EN_MEXT(1), .EN_HAZARD(1), .ILL_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_sigs(out_sigs),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_illegal(out_illegal),
    .ill_cnt(ill_cnt)
  );

  pipe_controller #(.EN_MEXT(0), .EN_HAZARD(1), .ILL_CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .instr(b_instr),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sigs(b_out_sigs),
    .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_illegal(b_out_illegal),
    .ill_cnt(b_ill_cnt)
  );

  localparam logic [31:0] ADD_X3 = 32'h002081B3;
  localparam logic [31:0] SUB_X3 = 32'h402081B3;
  localparam logic [31:0] MUL_X3 = 32'h022081B3;
  localparam logic [31:0] LW_X5  = 32'h0000A283;
  localparam logic [31:0] ADD_X6 = 32'h00228333;  // add x6,x5,x2
  localparam logic [31:0] LW_X0  = 32'h0000A003;
  localparam logic [31:0] ADD_X6_0 = 32'h00200333; // add x6,x0,x2
  localparam logic [31:0] SUB_X7 = 32'h402083B3;
  localparam logic [31:0] ILL    = 32'h0000007F;

  // Reference decode straight from the opcode table; returns the bundle laid
  // out as {immsel, alucontrol, alusrc, branch, pc_rs1_sel, memwrite, memread, regsrc, regwrite}.
  function automatic void ref_dec(input logic [31:0] i, input bit mext,
                                  output logic [14:0] s, output bit ill, output bit u1, output bit u2);
    bit rw, rsrc, mr, mw, pcs, br, as;
    logic [4:0] alu;
    logic [2:0] imm;
    logic [4:0] op;
    logic [2:0] f3;
    op = i[6:2]; f3 = i[14:12];
    {rw, rsrc, mr, mw, pcs, br, as} = '0;
    alu = 5'd0; imm = 3'd0; ill = 0;
    u1 = !(op == 5'b01101 || op == 5'b00101 || op == 5'b11011);
    u2 = (op == 5'b01100 || op == 5'b01000 || op == 5'b11000);
    case (op)
      5'b01100: begin rw = 1; if (i[25]) begin if (mext) alu = {2'b10, f3}; else ill = 1; end
                      else alu = {1'b0, i[30], f3}; end
      5'b00100: begin rw = 1; as = 1; alu = {1'b0, (f3 == 3'b101) ? i[30] : 1'b0, f3}; end
      5'b00000: begin rw = 1; rsrc = 1; mr = 1; as = 1; end
      5'b01000: begin mw = 1; as = 1; imm = 3'd1; end
      5'b11000: begin br = 1; alu = 5'b01000; imm = 3'd2; end
      5'b11011: begin rw = 1; br = 1; imm = 3'd4; end
      5'b11001: begin rw = 1; br = 1; pcs = 1; as = 1; end
      5'b01101, 5'b00101: begin rw = 1; as = 1; imm = 3'd3; end
      default: ill = 1;
    endcase
    if (ill) s = '0;
    else if (mext) s = {imm, alu, as, br, pcs, mw, mr, rsrc, rw};
    else s = {1'b0, imm, alu[3:0], as, br, pcs, mw, mr, rsrc, rw};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0] op;
    int k;
    r = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0, 1, 2: op = 5'b01100;
      3: op = 5'b00100;
      4: op = 5'b00000;
      5: op = 5'b01000;
      6: op = 5'b11000;
      7: op = 5'b11011;
      8: op = 5'b11001;
      9: op = 5'b01101;
      10: op = 5'b00101;
      default: op = ($urandom_range(0, 1) != 0) ? 5'b11111 : 5'b00011;
    endcase
    if (k == 0) r[31:25] = 7'b0000000;
    if (k == 1) r[31:25] = 7'b0100000;
    if (k == 2) r[31:25] = 7'b0000001;
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    r[6:0]   = {op, 2'b11};
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; flush = 0; out_ready = 0; instr = '0;
    b_in_valid = 0; b_flush = 0; b_out_ready = 0; b_instr = '0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_sigs !== 15'd0) begin errors++; $display("FAIL reset_sigs got=%h exp=0", out_sigs); end
    checks++; if ({out_rd, out_rs1, out_rs2, out_illegal} !== 16'd0) begin errors++; $display("FAIL reset_fields got=%h exp=0", {out_rd, out_rs1, out_rs2, out_illegal}); end
    checks++; if (ill_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", ill_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1; instr = ILL; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || ill_cnt !== 2'd1) begin errors++; $display("FAIL mid_pre got=%b/%0d exp=1/1", out_valid, ill_cnt); end
    #1 rst = 1;
    #1;
    checks++; if (out_valid !== 1'b0 || ill_cnt !== 2'd0) begin errors++; $display("FAIL mid_async got=%b/%0d exp=0/0", out_valid, ill_cnt); end
    #1 rst = 0;
    @(negedge clk);
    in_valid = 1; instr = ADD_X3; out_ready = 1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_idle got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_sigs !== 15'h0001) begin errors++; $display("FAIL mid_latency got=%b/%h exp=1/0001", out_valid, out_sigs); end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic test_decode();
    do_reset();
    in_valid = 1; instr = ADD_X3; out_ready = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_sigs !== 15'h0001) begin errors++; $display("FAIL dec_add got=%b/%h exp=1/0001", out_valid, out_sigs); end
    checks++; if ({out_rd, out_rs1, out_rs2} !== {5'd3, 5'd1, 5'd2}) begin errors++; $display("FAIL dec_regs got=%0d/%0d/%0d exp=3/1/2", out_rd, out_rs1, out_rs2); end
    instr = SUB_X3;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_sigs !== 15'h0401) begin errors++; $display("FAIL dec_sub got=%b/%h exp=1/0401", out_valid, out_sigs); end
    instr = MUL_X3;
    @(negedge clk);
    checks++; if (out_sigs !== 15'h0801 || out_illegal !== 1'b0) begin errors++; $display("FAIL dec_mul got=%h/%b exp=0801/0", out_sigs, out_illegal); end
    in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dec_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_load_use();
    do_reset();
    in_valid = 1; instr = LW_X5; out_ready = 1;
    @(negedge clk);
    instr = ADD_X6;
    #1;
    checks++; if (out_sigs !== 15'h0047) begin errors++; $display("FAIL lu_load_sigs got=%h exp=0047", out_sigs); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL lu_bubble got=%b/%b exp=0/1", out_valid, in_ready); end
    @(negedge clk);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd6) begin errors++; $display("FAIL lu_dep got=%b/%0d exp=1/6", out_valid, out_rd); end
    // load to x0 never stalls
    in_valid = 1; instr = LW_X0;
    @(negedge clk);
    instr = ADD_X6_0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_x0_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd6) begin errors++; $display("FAIL lu_x0_next got=%b/%0d exp=1/6", out_valid, out_rd); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1; instr = ADD_X3; out_ready = 0;
    @(negedge clk);
    instr = SUB_X7;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_sigs !== 15'h0001 || out_rd !== 5'd3 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got=%b/%h/%0d/%b exp=1/0001/3/0", c, out_valid, out_sigs, out_rd, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_sigs !== 15'h0401) begin errors++; $display("FAIL bp_next got=%b/%0d/%h exp=1/7/0401", out_valid, out_rd, out_sigs); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_nodup got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1; instr = ADD_X3; out_ready = 0;
    @(negedge clk);
    instr = SUB_X7; flush = 1; out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    flush = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fl_killed got=%b/%b exp=0/1", out_valid, in_ready); end
    @(negedge clk);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7) begin errors++; $display("FAIL fl_replay got=%b/%0d exp=1/7", out_valid, out_rd); end
  endtask

  task automatic test_illegal();
    do_reset();
    in_valid = 1; instr = ILL; out_ready = 1;
    @(negedge clk);
    checks++; if (out_illegal !== 1'b1 || out_sigs !== 15'd0 || ill_cnt !== 2'd1) begin errors++; $display("FAIL ill_first got=%b/%h/%0d exp=1/0/1", out_illegal, out_sigs, ill_cnt); end
    repeat (4) @(negedge clk);
    in_valid = 0;
    checks++; if (ill_cnt !== 2'd3) begin errors++; $display("FAIL ill_sat got=%0d exp=3", ill_cnt); end
    // base-ISA instance rejects MUL
    b_in_valid = 1; b_instr = MUL_X3; b_out_ready = 1;
    @(negedge clk);
    b_instr = ADD_X3;
    checks++; if (b_out_illegal !== 1'b1 || b_out_sigs !== 14'd0 || b_ill_cnt !== 16'd1) begin errors++; $display("FAIL mext_off got=%b/%h/%0d exp=1/0/1", b_out_illegal, b_out_sigs, b_ill_cnt); end
    @(negedge clk);
    b_in_valid = 0;
    checks++; if (b_out_illegal !== 1'b0 || b_out_sigs !== 14'h0001) begin errors++; $display("FAIL base_add got=%b/%h exp=0/0001", b_out_illegal, b_out_sigs); end
  endtask

  task automatic test_random();
    bit m_valid;
    logic [31:0] m_instr;
    int m_cnt;
    logic [14:0] es, ns;
    bit eill, u1, u2, nill, nu1, nu2, m_hz, e_ready;
    do_reset();
    m_valid = 0; m_instr = '0; m_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      instr     = rand_instr();
      #1;
      ref_dec(m_instr, 1'b1, es, eill, u1, u2);
      ref_dec(instr, 1'b1, ns, nill, nu1, nu2);
      m_hz = m_valid && es[2] && m_instr[11:7] != 5'd0 &&
             ((nu1 && instr[19:15] == m_instr[11:7]) || (nu2 && instr[24:20] == m_instr[11:7]));
      e_ready = (!m_valid || out_ready) && !flush && !m_hz;
      checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, e_ready); end
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, m_valid); end
      checks++; if (ill_cnt !== 2'(m_cnt)) begin errors++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, ill_cnt, m_cnt); end
      if (m_valid) begin
        checks++;
        if (out_sigs !== es || out_illegal !== eill || out_rd !== m_instr[11:7] ||
            out_rs1 !== m_instr[19:15] || out_rs2 !== m_instr[24:20]) begin
          errors++;
          $display("FAIL rnd_fields c=%0d instr=%h got=%h/%b/%0d/%0d/%0d exp=%h/%b/%0d/%0d/%0d", c, m_instr,
                   out_sigs, out_illegal, out_rd, out_rs1, out_rs2, es, eill, m_instr[11:7], m_instr[19:15], m_instr[24:20]);
        end
      end
      @(posedge clk);
      if (flush) m_valid = 0;
      else if (in_valid && e_ready) begin
        m_valid = 1; m_instr = instr;
        if (nill && m_cnt < 3) m_cnt++;
      end else if (out_ready) m_valid = 0;
      @(negedge clk);
    end
    in_valid = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_decode();
    test_load_use();
    test_backpressure();
    test_flush();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
